// File: rtl/axis_burst_pkg.sv
// Shared types and constants for the pulse-triggered AXI4-Stream burst generator.
package axis_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned FRAME_CNT_W = 16;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (maximal length).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/burst_pattern_gen.sv
// Data-word source for axis_burst_gen: incrementing counter by default,
// Galois LFSR when BURST_LFSR_EN is defined.
module burst_pattern_gen
  import axis_burst_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned INC    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] seed,
  input  logic              advance,
  output logic [DATA_W-1:0] word
);

  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] next_val;

`ifdef BURST_LFSR_EN
  // An all-zero LFSR state never leaves zero, so a zero seed is promoted to 1.
  always_comb begin
    load_val = (seed == '0) ? DATA_W'(1) : seed;
    next_val = word_q >> 1;
    if (word_q[0]) begin
      next_val = next_val ^ DATA_W'(LFSR_TAPS);
    end
  end
`else
  always_comb begin
    load_val = seed;
    next_val = word_q + DATA_W'(INC);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= load_val;
    end else if (advance) begin
      word_q <= next_val;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/axis_burst_gen.sv
// Pulse-triggered AXI4-Stream frame source for the DMA S2MM channel.
// Optional build macro BURST_LFSR_EN switches the data pattern to an LFSR.
module axis_burst_gen
  import axis_burst_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned INC    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_pulse,
  input  logic [LEN_W-1:0]       burst_len,
  input  logic [DATA_W-1:0]      seed,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic [DATA_W/8-1:0]    m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   busy,
  output logic                   done_pulse,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       beat_cnt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  logic tvalid;
  logic handshake;
  logic last_beat;
  logic load;
  logic advance;

  // Every output decodes registered state only; tready never reaches tvalid.
  assign tvalid    = (state_q == RUN);
  assign handshake = tvalid && m_axis_tready;
  assign last_beat = (beat_cnt_q == len_q - LEN_W'(1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          if (burst_len != '0) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (handshake) begin
          advance = 1'b1;
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // A zero-length start latches len 0, which later suppresses the frame count.
      if (state_q == IDLE && start_pulse) begin
        len_q      <= burst_len;
        beat_cnt_q <= '0;
      end else if (handshake) begin
        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
      end
      if (state_q == DONE && len_q != '0) begin
        frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
      end
    end
  end

  burst_pattern_gen #(
    .DATA_W (DATA_W),
    .INC    (INC)
  ) u_pattern (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .seed    (seed),
    .advance (advance),
    .word    (m_axis_tdata)
  );

  assign m_axis_tvalid = tvalid;
  assign m_axis_tkeep  = {(DATA_W/8){tvalid}};
  assign m_axis_tlast  = tvalid && last_beat;
  assign busy          = (state_q != IDLE);
  assign done_pulse    = (state_q == DONE);
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_burst_gen.sv
// Directed self-checking bench for axis_burst_gen (counter build, or LFSR build with BURST_LFSR_EN).
module tb_axis_burst_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_pulse;
  logic [15:0] burst_len;
  logic [31:0] seed;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        done_pulse;
  logic [15:0] frame_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  axis_burst_gen dut (
    .clk           (clk),
    .rst           (rst),
    .start_pulse   (start_pulse),
    .burst_len     (burst_len),
    .seed          (seed),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .frame_cnt     (frame_cnt)
  );

  // Expected i-th word of a frame started from s.
  function automatic logic [31:0] exp_word(input logic [31:0] s, input int i);
    logic [31:0] w;
`ifdef BURST_LFSR_EN
    w = (s == 32'h0) ? 32'h1 : s;
    for (int k = 0; k < i; k++) begin
      w = w[0] ? ((w >> 1) ^ 32'h8020_0003) : (w >> 1);
    end
`else
    w = s + 32'(i);
`endif
    return w;
  endfunction

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] len, input logic [31:0] s);
    burst_len   = len;
    seed        = s;
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start_pulse = 1'b0;
    burst_len = '0;
    seed = '0;
    m_axis_tready = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({m_axis_tvalid, m_axis_tlast, busy, done_pulse} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: valid/last/busy/done=%b required 0000",
               {m_axis_tvalid, m_axis_tlast, busy, done_pulse});
    end
    tests_run++;
    if ({m_axis_tdata, m_axis_tkeep, frame_cnt} !== 52'h0) begin
      tests_failed++;
      $display("FAIL reset_data: tdata=%h tkeep=%h frame_cnt=%0d required 0",
               m_axis_tdata, m_axis_tkeep, frame_cnt);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    m_axis_tready = 1'b1;
    start(16'd4, 32'h10);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_word(32'h10, i) ||
          m_axis_tlast !== (i == 3) || m_axis_tkeep !== 4'hF || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL basic_beat%0d: v=%b d=%h l=%b k=%h busy=%b required 1 %h %b F 1",
                 i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tkeep, busy,
                 exp_word(32'h10, i), (i == 3));
      end
      tick();
    end
    tests_run++;
    if (done_pulse !== 1'b1 || m_axis_tvalid !== 1'b0 || busy !== 1'b1 || frame_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL basic_done: done=%b v=%b busy=%b fc=%0d required 1 0 1 0",
               done_pulse, m_axis_tvalid, busy, frame_cnt);
    end
    tick();
    tests_run++;
    if (done_pulse !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL basic_after: done=%b busy=%b fc=%0d required 0 0 1", done_pulse, busy, frame_cnt);
    end
  endtask

  task automatic test_stall();
    logic [5:0] pat;
    int hs;
    pat = 6'b101001;  // bit k = tready in cycle k: 1,0,0,1,0,1
    hs  = 0;
    start(16'd3, 32'hA0);
    for (int k = 0; k < 6; k++) begin
      m_axis_tready = pat[k];
      tests_run++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_word(32'hA0, hs) ||
          m_axis_tlast !== (hs == 2)) begin
        tests_failed++;
        $display("FAIL stall_cyc%0d: v=%b d=%h l=%b required 1 %h %b",
                 k, m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_word(32'hA0, hs), (hs == 2));
      end
      if (m_axis_tvalid && m_axis_tready) hs++;
      tick();
    end
    m_axis_tready = 1'b1;
    tests_run++;
    if (hs !== 3 || done_pulse !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_done: handshakes=%0d done=%b busy=%b required 3 1 1", hs, done_pulse, busy);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || frame_cnt !== 16'd2) begin
      tests_failed++;
      $display("FAIL stall_after: busy=%b fc=%0d required 0 2", busy, frame_cnt);
    end
  endtask

  task automatic test_len_edges();
    start(16'd1, 32'h55);
    tests_run++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || m_axis_tdata !== exp_word(32'h55, 0)) begin
      tests_failed++;
      $display("FAIL len1_beat: v=%b l=%b d=%h required 1 1 %h",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, exp_word(32'h55, 0));
    end
    tick();
    tests_run++;
    if (done_pulse !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL len1_done: done=%b v=%b required 1 0", done_pulse, m_axis_tvalid);
    end
    tick();
    tests_run++;
    if (frame_cnt !== 16'd3) begin
      tests_failed++;
      $display("FAIL len1_count: fc=%0d required 3", frame_cnt);
    end
    start(16'd0, 32'h77);
    tests_run++;
    if (m_axis_tvalid !== 1'b0 || done_pulse !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL len0_done: v=%b done=%b busy=%b required 0 1 1", m_axis_tvalid, done_pulse, busy);
    end
    tick();
    tests_run++;
    if (m_axis_tvalid !== 1'b0 || done_pulse !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd3) begin
      tests_failed++;
      $display("FAIL len0_after: v=%b done=%b busy=%b fc=%0d required 0 0 0 3",
               m_axis_tvalid, done_pulse, busy, frame_cnt);
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    dones = 0;
    start(16'd8, 32'h200);
    for (int i = 0; i < 8; i++) begin
      start_pulse = (i == 3);
      burst_len   = 16'd2;
      seed        = 32'h999;
      tests_run++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_word(32'h200, i) || m_axis_tlast !== (i == 7)) begin
        tests_failed++;
        $display("FAIL ignore_beat%0d: v=%b d=%h l=%b required 1 %h %b",
                 i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_word(32'h200, i), (i == 7));
      end
      tick();
    end
    start_pulse = 1'b1;  // also lands in DONE and must be dropped
    if (done_pulse) dones++;
    tick();
    start_pulse = 1'b0;
    if (done_pulse) dones++;
    tests_run++;
    if (dones !== 1 || m_axis_tvalid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd4) begin
      tests_failed++;
      $display("FAIL ignore_end: dones=%0d v=%b busy=%b fc=%0d required 1 0 0 4",
               dones, m_axis_tvalid, busy, frame_cnt);
    end
    tick();
    tests_run++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_queued: v=%b busy=%b required 0 0", m_axis_tvalid, busy);
    end
  endtask

  task automatic test_wrap();
    start(16'd2, 32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (m_axis_tdata !== exp_word(32'hFFFF_FFFF, i) || m_axis_tlast !== (i == 1)) begin
        tests_failed++;
        $display("FAIL wrap_beat%0d: d=%h l=%b required %h %b",
                 i, m_axis_tdata, m_axis_tlast, exp_word(32'hFFFF_FFFF, i), (i == 1));
      end
      tick();
    end
    tick();
    tests_run++;
    if (frame_cnt !== 16'd5) begin
      tests_failed++;
      $display("FAIL wrap_count: fc=%0d required 5", frame_cnt);
    end
  endtask

  task automatic test_reset_mid();
    start(16'd6, 32'h300);
    tick();
    tick();
    tests_run++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_word(32'h300, 2)) begin
      tests_failed++;
      $display("FAIL midrst_beat2: v=%b d=%h required 1 %h", m_axis_tvalid, m_axis_tdata, exp_word(32'h300, 2));
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0 ||
        done_pulse !== 1'b0 || m_axis_tdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL midrst_clear: v=%b busy=%b fc=%0d done=%b d=%h required 0 0 0 0 0",
               m_axis_tvalid, busy, frame_cnt, done_pulse, m_axis_tdata);
    end
    rst = 1'b1;
    tick();
    start(16'd2, 32'h40);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_word(32'h40, i) || m_axis_tlast !== (i == 1)) begin
        tests_failed++;
        $display("FAIL midrst_new%0d: v=%b d=%h l=%b required 1 %h %b",
                 i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_word(32'h40, i), (i == 1));
      end
      tick();
    end
    tests_run++;
    if (done_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_done: done=%b required 1", done_pulse);
    end
    tick();
    tests_run++;
    if (frame_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL midrst_count: fc=%0d required 1", frame_cnt);
    end
  endtask

`ifdef BURST_LFSR_EN
  task automatic test_lfsr();
    logic [31:0] vec [4];
    vec = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
    start(16'd4, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (m_axis_tdata !== vec[i] || m_axis_tlast !== (i == 3)) begin
        tests_failed++;
        $display("FAIL lfsr_beat%0d: d=%h l=%b required %h %b", i, m_axis_tdata, m_axis_tlast, vec[i], (i == 3));
      end
      tick();
    end
    tests_run++;
    if (done_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL lfsr_done: done=%b required 1", done_pulse);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_len_edges();
    test_ignore_start();
    test_wrap();
    test_reset_mid();
`ifdef BURST_LFSR_EN
    test_lfsr();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axis_burst_gen.md
Name: axis_burst_gen

Overview:
- Pulse-triggered AXI4-Stream source that feeds the DMA S2MM channel, which writes to PL DDR.
- Consumes the one-cycle rising-edge pulse from the edge-detect stage (button/trigger → pulse). Each accepted pulse emits one frame of `burst_len` beats of a deterministic pattern, with TLAST on the final beat.
- Reports busy, a completion pulse and a running frame count for debug/ILA.

Parameters:
- DATA_W, 32, stream data width in bits; multiple of 8, ≥ 16.
- LEN_W, 16, width of the beat-count input.
- INC, 1, pattern increment added per accepted beat (counter mode).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- start_pulse  in  1  one-cycle trigger from the edge detector
- burst_len  in  LEN_W  beats per frame; sampled only when a start is accepted
- seed  in  DATA_W  first data word of the frame; sampled with burst_len
- m_axis_tdata  out  DATA_W  stream data
- m_axis_tkeep  out  DATA_W/8  byte enables; always all-ones while tvalid
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  downstream ready (DMA S2MM)
- m_axis_tlast  out  1  final beat of frame
- busy  out  1  high from the cycle after an accepted start until the done pulse, inclusive
- done_pulse  out  1  one cycle high after the last beat handshake
- frame_cnt  out  16  completed frames, wraps at 0xFFFF → 0

Behaviour:
- Reset: rst sampled low at posedge clears all state. Every output reads 0 the following cycle, including tvalid, tlast, tdata, tkeep, busy, done_pulse and frame_cnt.
- Reset mid-frame aborts immediately. Dropping tvalid without a handshake is permitted only under reset.
- FSM states:
  - IDLE: if start_pulse && burst_len != 0, latch len/seed, clear beat_cnt, go to RUN. If start_pulse && burst_len == 0, go to DONE with no beats emitted, and frame_cnt is NOT incremented.
  - RUN: tvalid = 1, tdata = current word, tkeep = all-ones. On each tvalid && tready handshake: beat_cnt += 1 and word += INC (modulo 2^DATA_W, wraps silently). On the handshake where beat_cnt == len-1, go to DONE.
  - DONE: done_pulse = 1 for exactly one cycle, then return to IDLE. frame_cnt += 1 on leaving DONE when len != 0.
- Latency:
  - First tvalid appears 1 cycle after start_pulse is sampled.
  - done_pulse appears 1 cycle after the last handshake.
  - A new start is accepted no earlier than the IDLE cycle following DONE.
- AXIS rules:
  - While tvalid && !tready, tdata/tlast/tkeep stay stable.
  - tvalid never deasserts before the handshake.
  - tvalid does not depend combinationally on tready.
- tlast: asserted exactly when beat_cnt == len-1 and tvalid. len == 1 means the first beat carries tlast.
- start_pulse while busy (RUN or DONE) is ignored and not queued. burst_len/seed changes during RUN have no effect.
- All outputs are registered; there are no combinational input-to-output paths.
- len = 2^LEN_W-1 is supported. beat_cnt is LEN_W bits and cannot overflow.

Optional Feature:
- Macro BURST_LFSR_EN.
- Defined: the data pattern is a Galois LFSR of width DATA_W, loaded from seed (a seed of 0 is replaced by 1). It advances one step per handshake instead of adding INC, using a fixed maximal-length tap constant for DATA_W = 32 held in the package.
- Undefined: incrementing counter as above. Ports and timing are identical in both builds.

Decomposition:
- Package axis_burst_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE)
  - the LFSR tap constant
  - the frame_cnt width constant (16)
- One natural sub-module: burst_pattern_gen. It takes load/seed/advance and outputs the word, and contains the counter or LFSR under BURST_LFSR_EN. The FSM and handshake stay in the top.

Test Plan:
- Reset then start, len=4, seed=0x10, tready=1 → tdata 0x10,0x11,0x12,0x13 on consecutive cycles; tlast on 0x13 only; done_pulse 1 cycle later; frame_cnt=1.
- len=3, seed=0xA0, tready toggling 1,0,0,1,0,1 → data and tlast held stable during stalls; exactly 3 handshakes (0xA0,0xA1,0xA2); busy deasserts after done_pulse.
- len=1 → single beat with tlast=1. Then len=0 → no tvalid, done_pulse 1 cycle after start, frame_cnt unchanged.
- start_pulse re-asserted mid-frame (len=8) → ignored; exactly 8 beats and 1 done_pulse. Seed 0xFFFFFFFF, len=2 → 0xFFFFFFFF then 0x00000000.
- rst low during beat 2 of len=6 → next cycle tvalid=0, busy=0, frame_cnt=0. New start then produces a clean frame from the new seed.
- With BURST_LFSR_EN, seed=0 → first word 0x00000001, then the LFSR sequence matching the reference model; tlast/timing identical to the counter build.
